// File: rtl/sort4_rr_arbiter.sv
// sort4_rr_arbiter: round-robin share of one 4-element sort engine (req/ack in, start/done to engine, id-tagged valid/ready result out, done watchdog)
module sort4_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 15,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              eng_start,
  output logic [7:0]        eng_i0,
  output logic [7:0]        eng_i1,
  output logic [7:0]        eng_i2,
  output logic [7:0]        eng_i3,
  input  logic [7:0]        eng_R0,
  input  logic [7:0]        eng_R1,
  input  logic [7:0]        eng_R2,
  input  logic [7:0]        eng_R3,
  input  logic              eng_done
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t state, state_d;
  logic [IDW-1:0] ptr, ptr_d, g, g_hi, g_lo, id_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0] ops, ops_d, data_d;
  logic hit, hi_hit, valid_d, err_d, start_d;
  logic [NREQ-1:0] ack_d;
  assign {eng_i3, eng_i2, eng_i1, eng_i0} = ops;
  always_comb begin
    hit = |req;
    hi_hit = 1'b0;
    g_hi = '0;
    g_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) g_lo = IDW'(i);
      if (req[i] && i >= int'(ptr)) begin
        hi_hit = 1'b1;
        g_hi = IDW'(i);
      end
    end
    g = hi_hit ? g_hi : g_lo;
  end
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    cnt_d = cnt;
    ops_d = ops;
    id_d = rsp_id;
    data_d = rsp_data;
    valid_d = rsp_valid;
    err_d = rsp_err;
    ack_d = '0;
    start_d = 1'b0;
    case (state)
      IDLE: if (hit) begin
        state_d = LAUNCH;
        ack_d = NREQ'(1) << g;
        start_d = 1'b1;
        ops_d = req_data[32*g +: 32];
        id_d = g;
        ptr_d = (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
      end
      LAUNCH: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt + 1'b1;
        if (eng_done || cnt == CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          valid_d = 1'b1;
          err_d = !eng_done;
          data_d = eng_done ? {eng_R3, eng_R2, eng_R1, eng_R0} : ops;
        end
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
        err_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      ops <= '0;
      ack <= '0;
      eng_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      cnt <= cnt_d;
      ops <= ops_d;
      ack <= ack_d;
      eng_start <= start_d;
      rsp_valid <= valid_d;
      rsp_id <= id_d;
      rsp_data <= data_d;
      rsp_err <= err_d;
      busy <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_sort4_rr_arbiter.sv
// tb_sort4_rr_arbiter: directed and randomized checks of sort4_rr_arbiter against a cycle-timed behavioural model
module tb_sort4_rr_arbiter;
  localparam int NREQ = 4;
  localparam int TIMEOUT = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*32-1:0] req_data = '0;
  logic [NREQ-1:0] ack;
  logic rsp_valid, rsp_err, busy, eng_start, eng_done;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [31:0] rsp_data;
  logic [7:0] eng_i0, eng_i1, eng_i2, eng_i3, eng_R0, eng_R1, eng_R2, eng_R3;
  logic eng_en = 1'b1;
  logic stray = 1'b0;
  logic chk_en = 1'b0;
  logic [4:0] pipe;
  int checks = 0;
  int errors = 0;
  bit m_job = 0, m_resp = 0, m_err = 0;
  int m_age = 0, m_ptr = 0, m_id = 0;
  logic [31:0] m_data = '0, m_ei = '0;

  always #5 clk = ~clk;

  sort4_rr_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .eng_start(eng_start),
    .eng_i0(eng_i0), .eng_i1(eng_i1), .eng_i2(eng_i2), .eng_i3(eng_i3),
    .eng_R0(eng_R0), .eng_R1(eng_R1), .eng_R2(eng_R2), .eng_R3(eng_R3), .eng_done(eng_done)
  );

  function automatic logic [31:0] sort4(input logic [31:0] w);
    logic [7:0] b[4];
    logic [7:0] t;
    for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (b[j] > b[j+1]) begin
          t = b[j];
          b[j] = b[j+1];
          b[j+1] = t;
        end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 3))
        0: w[8*k +: 8] = 8'h00;
        1: w[8*k +: 8] = 8'hFF;
        2: w[8*k +: 8] = 8'h7F;
        default: w[8*k +: 8] = 8'($urandom);
      endcase
    end
    return w;
  endfunction

  // engine stub: done five cycles after start, results only meaningful while done
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pipe <= '0;
    else pipe <= {pipe[3:0], eng_start};
  assign eng_done = (pipe[4] & eng_en) | stray;
  assign {eng_R3, eng_R2, eng_R1, eng_R0} = eng_done ? sort4({eng_i3, eng_i2, eng_i1, eng_i0}) : 32'hA55A3CC3;

  // model: m_age counts cycles since the grant cycle (1 = ack/start cycle, 2.. = waiting for done)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_job = 0; m_resp = 0; m_err = 0; m_age = 0; m_ptr = 0; m_id = 0; m_data = '0; m_ei = '0;
    end else if (!m_job) begin
      for (int k = 0; k < NREQ; k++)
        if (!m_job && req[(m_ptr + k) % NREQ]) begin
          m_id = (m_ptr + k) % NREQ;
          m_job = 1;
          m_age = 1;
          m_ei = req_data[32*m_id +: 32];
          m_ptr = (m_id + 1) % NREQ;
        end
    end else if (m_resp) begin
      if (rsp_ready) begin
        m_resp = 0; m_err = 0; m_job = 0;
      end
    end else begin
      if (m_age >= 2 && eng_done) begin
        m_resp = 1; m_err = 0; m_data = sort4(m_ei);
      end else if (m_age == TIMEOUT + 1) begin
        m_resp = 1; m_err = 1; m_data = m_ei;
      end
      m_age++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n && chk_en) begin
      chk("ack", 32'(ack), (m_job && !m_resp && m_age == 1) ? (32'd1 << m_id) : 32'd0);
      chk("eng_start", 32'(eng_start), 32'(m_job && !m_resp && m_age == 1));
      chk("busy", 32'(busy), 32'(m_job));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_data", rsp_data, m_data);
      chk("eng_i", {eng_i3, eng_i2, eng_i1, eng_i0}, m_ei);
    end

  task automatic run_job(input int id, input logic [31:0] d, input logic [31:0] exp, input string nm);
    req[id] = 1'b1;
    req_data[32*id +: 32] = d;
    @(negedge clk);
    chk({nm, "_ack"}, 32'(ack), 32'd1 << id);
    chk({nm, "_start"}, 32'(eng_start), 32'd1);
    req[id] = 1'b0;
    repeat (6) @(negedge clk);
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_id"}, 32'(rsp_id), 32'(id));
    chk({nm, "_data"}, rsp_data, exp);
    chk({nm, "_err"}, 32'(rsp_err), 32'd0);
    @(negedge clk);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic zero_outputs(input string nm);
    chk({nm, "_ack"}, 32'(ack), 32'd0);
    chk({nm, "_start"}, 32'(eng_start), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_err"}, 32'(rsp_err), 32'd0);
    chk({nm, "_id"}, 32'(rsp_id), 32'd0);
    chk({nm, "_data"}, rsp_data, 32'd0);
    chk({nm, "_eng_i"}, {eng_i3, eng_i2, eng_i1, eng_i0}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int order[$];
    int times[$];
    logic [3:0] reraise;
    int c;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    zero_outputs("reset");
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    run_job(2, 32'h20304010, 32'h40302010, "single");
    run_job(1, 32'hFF00FF00, 32'hFFFF0000, "dup");
    run_job(0, 32'h7F7F7F7F, 32'h7F7F7F7F, "flat");

    do_reset();
    req_data = {32'h44434241, 32'h34333231, 32'h24232221, 32'h14131211};
    @(negedge clk);
    req = 4'hF;
    reraise = '0;
    for (c = 0; c < 60 && order.size() < 5; c++) begin
      @(negedge clk);
      req |= reraise;
      reraise = '0;
      if (ack != '0) begin
        for (int i = 0; i < NREQ; i++) if (ack[i]) order.push_back(i);
        times.push_back(c);
        req &= ~ack;
        reraise = ack;
      end
    end
    req = '0;
    chk("fair_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size(); i++) begin
      chk("fair_order", 32'(order[i]), 32'(i % NREQ));
      if (i > 0) chk("fair_spacing", 32'(times[i] - times[i-1]), 32'd8);
    end
    for (c = 0; c < 40 && busy; c++) @(negedge clk);
    chk("fair_drain", 32'(busy), 32'd0);

    req[2] = 1'b1;
    req_data[95:64] = 32'h9C015E2A;
    for (c = 0; c < 5 && !ack[2]; c++) @(negedge clk);
    chk("bp_ack", 32'(ack), 32'b0100);
    req[2] = 1'b0;
    req[0] = 1'b1;
    req_data[31:0] = 32'h11223344;
    rsp_ready = 1'b0;
    for (c = 0; c < 20 && !rsp_valid; c++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'h9C5E2A01);
      chk("bp_id", 32'(rsp_id), 32'd2);
      chk("bp_no_ack", 32'({ack, eng_start}), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_h1_ack", 32'(ack), 32'd0);
    chk("bp_h1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("bp_h2_ack", 32'(ack), 32'b0001);
    chk("bp_h2_start", 32'(eng_start), 32'd1);
    req[0] = 1'b0;
    for (c = 0; c < 20 && !rsp_valid; c++) @(negedge clk);
    chk("bp_second_data", rsp_data, 32'h44332211);
    @(negedge clk);

    eng_en = 1'b0;
    req[1] = 1'b1;
    req_data[63:32] = 32'h04030201;
    @(negedge clk);
    chk("wd_ack", 32'(ack), 32'b0010);
    req[1] = 1'b0;
    repeat (15) @(negedge clk);
    chk("wd_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("wd_valid", 32'(rsp_valid), 32'd1);
    chk("wd_err", 32'(rsp_err), 32'd1);
    chk("wd_id", 32'(rsp_id), 32'd1);
    chk("wd_data", rsp_data, 32'h04030201);
    repeat (3) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("wd_stray_valid", 32'(rsp_valid), 32'd0);
    chk("wd_stray_busy", 32'(busy), 32'd0);
    chk("wd_stray_data", rsp_data, 32'h04030201);
    @(negedge clk);
    eng_en = 1'b1;

    req[0] = 1'b1;
    req_data[31:0] = 32'h01020304;
    @(negedge clk);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 zero_outputs("rst_wait");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_job(3, 32'h00FF8001, 32'hFF800100, "post_rst");

    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      stray = 1'b0;
      for (int i = 0; i < NREQ; i++)
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[32*i +: 32] = rnd_word();
        end else if (req[i] && $urandom_range(0, 80) == 0) req[i] = 1'b0;
      rsp_ready = $urandom_range(0, 2) != 0;
      eng_en = $urandom_range(0, 7) != 0;
      if (!(m_job && !m_resp && m_age >= 2) && $urandom_range(0, 11) == 0) stray = 1'b1;
      if ($urandom_range(0, 249) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    stray = 1'b0;
    req = '0;
    eng_en = 1'b1;
    rsp_ready = 1'b1;
    for (c = 0; c < 40 && busy; c++) @(negedge clk);
    chk("final_drain", 32'(busy), 32'd0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
